// File: rtl/levitator_pkg.sv
// levitator_pkg
// Shared definitions for the levitator host command path: opcode values,
// framing FSM states and frame layout constants.
package levitator_pkg;

   localparam logic [1:0] OP_WRITE  = 2'b00;
   localparam logic [1:0] OP_RELOAD = 2'b01;
   localparam logic [1:0] OP_COUNT  = 2'b10;
   localparam logic [1:0] OP_STATUS = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      GOT1,
      GOT2,
      RESP
   } state_t;

   // Bit 7 set marks a frame header; data bytes always have it clear.
   localparam int HDR_BIT   = 7;
   localparam int FRAME_LEN = 3;

   function automatic logic is_header(input logic [7:0] b);
      return b[HDR_BIT];
   endfunction

endpackage

// File: rtl/levitator_cmd_ctrl_if.sv
// levitator_cmd_ctrl_if
// Bundles the UART receive stream, UART transmit stream, phase-offset write
// port, reload strobe, error counter and FSM debug state of the command
// controller.
//   master : the controller (drives rx_ready, tx_*, wr_*, reload_n,
//            err_count, fsm_state)
//   slave  : the surrounding UART / offset bank
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// The source holds valid and data stable until that edge; ready may change
// freely and is never a function of valid within the same cycle.
interface levitator_cmd_ctrl_if
   import levitator_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 7,
   parameter int OFFSET_WIDTH = 11
) ();

   logic [DATA_WIDTH-1:0]   rx_data;
   logic                    rx_valid;
   logic                    rx_ready;
   logic [DATA_WIDTH-1:0]   tx_data;
   logic                    tx_valid;
   logic                    tx_ready;
   logic                    wr_en;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [OFFSET_WIDTH-1:0] wr_data;
   logic                    reload_n;
   logic [7:0]              err_count;
   state_t                  fsm_state;

   modport master (
      input  rx_data, rx_valid, tx_ready,
      output rx_ready, tx_data, tx_valid, wr_en, wr_addr, wr_data,
             reload_n, err_count, fsm_state
   );

   modport slave (
      output rx_data, rx_valid, tx_ready,
      input  rx_ready, tx_data, tx_valid, wr_en, wr_addr, wr_data,
             reload_n, err_count, fsm_state
   );

endinterface

// File: rtl/levitator_cmd_ctrl.sv
// levitator_cmd_ctrl
// Frames 3-byte host commands from the UART receive stream, resynchronises
// on header bytes, drops stalled partial frames after TIMEOUT idle cycles,
// issues one-cycle offset writes / reload pulses and answers queries on the
// UART transmit stream. Protocol errors are counted (saturating at 255).
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   bus  - levitator_cmd_ctrl_if.master (rx/tx streams, write port,
//          reload_n, err_count, fsm_state debug)
module levitator_cmd_ctrl
   import levitator_pkg::*;
#(
   parameter int OUTPUTS      = 88,
   parameter int OFFSET_WIDTH = 11,
   parameter int DATA_WIDTH   = 8,
   parameter int TIMEOUT      = 50000,
   parameter int ADDR_WIDTH   = $clog2(OUTPUTS)
) (
   input logic                  clk,
   input logic                  rst,
   levitator_cmd_ctrl_if.master bus
);

   localparam int               CNT_W        = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [8:0]       OUTPUTS_LIM  = 9'(OUTPUTS);

   state_t                  state_q, state_nx;
   logic [CNT_W-1:0]        idle_q, idle_nx;
   logic [1:0]              op_q, op_nx;
   logic [4:0]              addr_hi_q, addr_hi_nx;
   logic [2:0]              addr_lo_q, addr_lo_nx;
   logic [3:0]              off_hi_q, off_hi_nx;

   logic                    rx_ready_q, rx_ready_nx;
   logic                    tx_valid_q, tx_valid_nx;
   logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_nx;
   logic                    wr_en_q, wr_en_nx;
   logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_nx;
   logic [OFFSET_WIDTH-1:0] wr_data_q, wr_data_nx;
   logic                    reload_n_q, reload_n_nx;
   logic [7:0]              err_q, err_nx;

   logic                    accept, hdr, err_evt, err_clr;
   logic [7:0]              frame_addr;
   logic [10:0]             frame_off;

   assign accept     = bus.rx_valid && rx_ready_q;
   assign hdr        = is_header(bus.rx_data);
   assign frame_addr = {addr_hi_q, addr_lo_q};
   // Offset low bits come straight from Byte2 as it is accepted.
   assign frame_off  = {off_hi_q, bus.rx_data[6:0]};

   always_comb begin
      state_nx    = state_q;
      idle_nx     = idle_q;
      op_nx       = op_q;
      addr_hi_nx  = addr_hi_q;
      addr_lo_nx  = addr_lo_q;
      off_hi_nx   = off_hi_q;
      tx_valid_nx = tx_valid_q;
      tx_data_nx  = tx_data_q;
      wr_en_nx    = 1'b0;
      wr_addr_nx  = wr_addr_q;
      wr_data_nx  = wr_data_q;
      reload_n_nx = 1'b1;
      err_evt     = 1'b0;
      err_clr     = 1'b0;

      // A header byte always (re)starts a frame, whatever the state.
      if (accept && hdr) begin
         op_nx      = bus.rx_data[6:5];
         addr_hi_nx = bus.rx_data[4:0];
      end

      case (state_q)
         IDLE: begin
            idle_nx = '0;
            if (accept) begin
               if (hdr) state_nx = GOT1;
               else     err_evt  = 1'b1;
            end
         end
         GOT1, GOT2: begin
            if (accept) begin
               idle_nx = '0;
               if (hdr) begin
                  state_nx = GOT1;
                  err_evt  = 1'b1;
               end else if (state_q == GOT1) begin
                  addr_lo_nx = bus.rx_data[6:4];
                  off_hi_nx  = bus.rx_data[3:0];
                  state_nx   = GOT2;
               end else begin
                  state_nx = IDLE;
                  case (op_q)
                     OP_WRITE: begin
                        if ({1'b0, frame_addr} < OUTPUTS_LIM) begin
                           wr_en_nx   = 1'b1;
                           wr_addr_nx = ADDR_WIDTH'(frame_addr);
                           wr_data_nx = OFFSET_WIDTH'(frame_off);
                        end else begin
                           err_evt = 1'b1;
                        end
                     end
                     OP_RELOAD: reload_n_nx = 1'b0;
                     OP_COUNT: begin
                        tx_data_nx  = DATA_WIDTH'(OUTPUTS);
                        tx_valid_nx = 1'b1;
                        state_nx    = RESP;
                     end
                     default: begin
                        tx_data_nx  = DATA_WIDTH'(err_q);
                        tx_valid_nx = 1'b1;
                        err_clr     = 1'b1;
                        state_nx    = RESP;
                     end
                  endcase
               end
            end else if (idle_q == TIMEOUT_LAST) begin
               // This edge completes TIMEOUT idle cycles: drop the frame.
               idle_nx  = '0;
               state_nx = IDLE;
               err_evt  = 1'b1;
            end else begin
               idle_nx = idle_q + CNT_W'(1);
            end
         end
         RESP: begin
            idle_nx = '0;
            if (tx_valid_q && bus.tx_ready) begin
               tx_valid_nx = 1'b0;
               state_nx    = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase

      // Input is only closed while a response is outstanding.
      rx_ready_nx = (state_nx != RESP);

      err_nx = err_q;
      if (err_clr)
         err_nx = '0;
      else if (err_evt && err_q != 8'hFF)
         err_nx = err_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         idle_q     <= '0;
         op_q       <= '0;
         addr_hi_q  <= '0;
         addr_lo_q  <= '0;
         off_hi_q   <= '0;
         rx_ready_q <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         reload_n_q <= 1'b1;
         err_q      <= '0;
      end else begin
         state_q    <= state_nx;
         idle_q     <= idle_nx;
         op_q       <= op_nx;
         addr_hi_q  <= addr_hi_nx;
         addr_lo_q  <= addr_lo_nx;
         off_hi_q   <= off_hi_nx;
         rx_ready_q <= rx_ready_nx;
         tx_valid_q <= tx_valid_nx;
         tx_data_q  <= tx_data_nx;
         wr_en_q    <= wr_en_nx;
         wr_addr_q  <= wr_addr_nx;
         wr_data_q  <= wr_data_nx;
         reload_n_q <= reload_n_nx;
         err_q      <= err_nx;
      end
   end

   assign bus.rx_ready  = rx_ready_q;
   assign bus.tx_valid  = tx_valid_q;
   assign bus.tx_data   = tx_data_q;
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.reload_n  = reload_n_q;
   assign bus.err_count = err_q;
   assign bus.fsm_state = state_q;

endmodule
